pipe_stage_skid_reg: RTL
========================

# pipe_stage_skid_reg

Parametrised pipeline stage register for the five-stage CPU. It carries source/destination register addresses and control bits between stages. It adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure is absorbed without loss. A flush kills all in-flight entries, and stall and flush events are counted for performance analysis.

## Interface
Parameters:
- ADDR_W, 5, width of one register address
- NUM_SRC, 2, number of source-address fields (rs1, rs2, ...)
- CTRL_W, 1, control bits (e.g. memory write enable); forced to 0 on flush or when the stage is empty
- CNT_W, 16, width of the saturating performance counters

Ports:
- CLK  in  1  clock; all state updates on the falling edge, matching the other stage registers
- Reset  in  1  synchronous, active-high reset
- flush  in  1  kill all held entries this edge (the `clear` role of the older stage registers)
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat
- rsIn  in  NUM_SRC*ADDR_W  source addresses; field k is at bits [k*ADDR_W +: ADDR_W]
- rdIn  in  ADDR_W  destination address
- ctrlIn  in  CTRL_W  control bits
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts the head entry
- rsOut  out  NUM_SRC*ADDR_W  head source addresses
- rdOut  out  ADDR_W  head destination address
- ctrlOut  out  CTRL_W  head control bits; 0 whenever out_valid=0
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
- flush_cnt  out  CNT_W  edges on which flush=1

## Operation
- Storage: a head entry (main) and a skid entry. Each entry holds a valid bit, rs, rd and ctrl.
- Output ports are driven only from the main entry. in_ready = !skid.valid and is a function of state only; there is no combinational in→out path.
- Accept: when in_valid && in_ready, the beat is written to the first free slot in order main, then skid. If main is being consumed on the same edge, the beat goes to main.
- Consume: when out_valid && out_ready, main empties. If skid is valid, skid moves into main on the same edge.
- Order is strictly FIFO; beats are never reordered or duplicated.
- Priority is Reset > flush > handshake.
- Reset: both entries invalid. rs, rd and ctrl are all 0 in both entries. Both counters are 0.
- flush: both entries become invalid and their ctrl is cleared to 0. rs and rd hold their values. A beat offered on the flush edge is dropped, even though it counts as accepted if in_ready=1, because upstream is flushed too. The consume on that edge is ignored.
- Entry invalidation clears ctrl in every case (consume with no refill, or flush), so ctrlOut is never non-zero while out_valid=0.
- Counters saturate at 2^CNT_W-1. They are not cleared by flush.

## Timing
- Reset values: out_valid=0, in_ready=1, rsOut=0, rdOut=0, ctrlOut=0, stall_cnt=0, flush_cnt=0.
- Latency: a beat accepted at edge n is on the outputs after edge n when the stage was empty.
- Throughput: 1 beat per cycle while out_ready=1.
- Back-pressure:
  - out_ready low with main full: the next accepted beat lands in skid.
  - in_ready falls after that edge.
  - in_ready rises on the edge after a consume that empties skid.
- Simultaneous consume and accept with skid full is impossible, because in_ready=0.
- Simultaneous consume and accept with only main full: main takes skid if valid, otherwise the new beat. It never takes both.
- Reset or flush asserted mid-stall takes effect at that edge. out_valid=0 the following cycle.

## Structure
- Shared package pipe_pkg: ADDR_W default (5), REG_ZERO constant, CNT_W default, and a typedef for the stage entry {valid, rs, rd, ctrl}.
- One sub-module: stage_entry_reg. It is a single entry with load, kill and reset inputs and the ctrl-clear-on-kill rule, instantiated twice (main, skid).
- Handshake/steering logic and the counters live in the top module.

## Test plan
- Reset held for 2 cycles with in_valid=1 → out_valid=0, ctrlOut=0, in_ready=1, both counters 0 after release.
- Streaming: rd=1,2,3 with ctrl=1 and out_ready=1 → rdOut shows 1,2,3 on consecutive cycles, one cycle after each input, with no gaps.
- Stall: out_ready=0 while feeding rd=4,5,6 → rd=4 in main, rd=5 in skid, in_ready=0 and rd=6 held upstream. Release out_ready → outputs 4,5,6 in order; stall_cnt equals the stalled cycles.
- Flush with both entries full (ctrl=1) → out_valid=0 and ctrlOut=0 next cycle, in_ready=1, flush_cnt=1. A beat offered on the flush edge never appears.
- Simultaneous consume+accept with main full and skid empty → the new beat is in main after the edge, skid stays empty, and in_ready stays 1.
- Counter saturation with CNT_W=3 and out_ready=0 for 10 valid cycles → stall_cnt stops at 7.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU pipeline stage registers.
// Default field widths, the zero register address and the stage-entry layout.
package pipe_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int NUM_SRC_DEF = 2;
  localparam int CTRL_W_DEF  = 1;
  localparam int CNT_W_DEF   = 16;

  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                              valid;
    logic [NUM_SRC_DEF*ADDR_W_DEF-1:0] rs;
    logic [ADDR_W_DEF-1:0]             rd;
    logic [CTRL_W_DEF-1:0]             ctrl;
  } stage_entry_t;

endpackage

// File: rtl/stage_entry_reg.sv
// One pipeline entry (valid, rs, rd, ctrl) updated on the falling clock edge.
// Reset > kill > load; kill drops valid and ctrl but keeps rs/rd, so ctrl is 0 whenever invalid.
module stage_entry_reg
  import pipe_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int CTRL_W  = CTRL_W_DEF
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic                      kill,
  input  logic                      load,
  input  logic [NUM_SRC*ADDR_W-1:0] rs_d,
  input  logic [ADDR_W-1:0]         rd_d,
  input  logic [CTRL_W-1:0]         ctrl_d,
  output logic                      valid_q,
  output logic [NUM_SRC*ADDR_W-1:0] rs_q,
  output logic [ADDR_W-1:0]         rd_q,
  output logic [CTRL_W-1:0]         ctrl_q
);

  always_ff @(negedge CLK) begin
    if (Reset) begin
      valid_q <= 1'b0;
      rs_q    <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else if (kill) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      rs_q    <= rs_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with a main entry plus one skid entry; 1-cycle latency, full throughput.
// in_ready = !skid valid (state only), so back-pressure is absorbed without loss; flush kills both.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int CTRL_W  = CTRL_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_SRC*ADDR_W-1:0] rsIn,
  input  logic [ADDR_W-1:0]         rdIn,
  input  logic [CTRL_W-1:0]         ctrlIn,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_SRC*ADDR_W-1:0] rsOut,
  output logic [ADDR_W-1:0]         rdOut,
  output logic [CTRL_W-1:0]         ctrlOut,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  localparam int                RS_W    = NUM_SRC * ADDR_W;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              main_v, skid_v;
  logic [RS_W-1:0]   main_rs, skid_rs;
  logic [ADDR_W-1:0] main_rd, skid_rd;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

  logic              accept, consume;
  logic              load_main, kill_main, load_skid, kill_skid;
  logic [RS_W-1:0]   main_rs_d;
  logic [ADDR_W-1:0] main_rd_d;
  logic [CTRL_W-1:0] main_ctrl_d;

  assign in_ready = !skid_v;
  assign accept   = in_valid && in_ready;
  assign consume  = main_v && out_ready;

  // Main refills from skid first (older beat), else from the input; skid only
  // catches a beat when main is occupied and not draining this edge.
  always_comb begin
    load_main   = !flush && ((consume && (skid_v || accept)) || (!main_v && accept));
    kill_main   = flush || (consume && !skid_v && !accept);
    load_skid   = !flush && accept && main_v && !consume;
    kill_skid   = flush || (skid_v && consume);
    main_rs_d   = skid_v ? skid_rs   : rsIn;
    main_rd_d   = skid_v ? skid_rd   : rdIn;
    main_ctrl_d = skid_v ? skid_ctrl : ctrlIn;
  end

  stage_entry_reg #(
    .ADDR_W  (ADDR_W),
    .NUM_SRC (NUM_SRC),
    .CTRL_W  (CTRL_W)
  ) u_main (
    .CLK     (CLK),
    .Reset   (Reset),
    .kill    (kill_main),
    .load    (load_main),
    .rs_d    (main_rs_d),
    .rd_d    (main_rd_d),
    .ctrl_d  (main_ctrl_d),
    .valid_q (main_v),
    .rs_q    (main_rs),
    .rd_q    (main_rd),
    .ctrl_q  (main_ctrl)
  );

  stage_entry_reg #(
    .ADDR_W  (ADDR_W),
    .NUM_SRC (NUM_SRC),
    .CTRL_W  (CTRL_W)
  ) u_skid (
    .CLK     (CLK),
    .Reset   (Reset),
    .kill    (kill_skid),
    .load    (load_skid),
    .rs_d    (rsIn),
    .rd_d    (rdIn),
    .ctrl_d  (ctrlIn),
    .valid_q (skid_v),
    .rs_q    (skid_rs),
    .rd_q    (skid_rd),
    .ctrl_q  (skid_ctrl)
  );

  assign out_valid = main_v;
  assign rsOut     = main_rs;
  assign rdOut     = main_rd;
  assign ctrlOut   = main_ctrl;

  // Counters survive flush; only Reset clears them.
  always_ff @(negedge CLK) begin
    if (Reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (main_v && !out_ready && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_ONE;
      if (flush && (flush_cnt != CNT_MAX))
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule
